// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-rate tick generator.
package tick_gen_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Reload value giving a 60 Hz period from a 50 MHz clock.
  localparam int unsigned DIV_60HZ_50M = 833332;

  function automatic int unsigned ch_w(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_rate_tick_gen_channel.sv
// One programmable tick channel: down-counter, divisor, mode, arm flag and registered tick.
module multi_rate_tick_gen_channel
  import tick_gen_pkg::*;
#(
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned DEFAULT_DIV = DIV_60HZ_50M
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             ch_en_i,
  input  logic             restart_i,
  input  logic             cfg_we_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic             cfg_oneshot_i,
  output logic             tick_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] DivRst = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic             armed_q, armed_d;
  logic             tick_q, tick_d;
  logic             run;

  always_comb begin
    run     = enable_i & ch_en_i & armed_q;
    div_d   = cfg_we_i ? cfg_div_i : div_q;
    mode_d  = cfg_we_i ? cfg_oneshot_i : mode_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    tick_d  = 1'b0;
    if (restart_i) begin
      // Restart wins over counting and picks up a divisor written in the same cycle.
      cnt_d   = div_d;
      armed_d = 1'b1;
    end else if (run) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        tick_d = 1'b1;
        cnt_d  = div_q;
        if (mode_q == MODE_ONESHOT) armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= DivRst;
      div_q   <= DivRst;
      mode_q  <= MODE_PERIODIC;
      armed_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o = tick_q;
  assign busy_o = armed_q & ch_en_i;

endmodule

// File: rtl/multi_rate_tick_gen.sv
// NUM_CH independent programmable tick generators with a shared config write port.
module multi_rate_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned DEFAULT_DIV = DIV_60HZ_50M,
  localparam int unsigned CH_W       = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] restart,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] cfg_hit;

  // Out-of-range channel numbers match no channel, so such writes are dropped.
  always_comb begin
    cfg_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cfg_hit[i] = cfg_we && (32'(cfg_ch) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    multi_rate_tick_gen_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_i        (clk),
      .reset_i      (reset),
      .enable_i     (enable),
      .ch_en_i      (ch_en[g]),
      .restart_i    (restart[g]),
      .cfg_we_i     (cfg_hit[g]),
      .cfg_div_i    (cfg_div),
      .cfg_oneshot_i(cfg_oneshot),
      .tick_o       (tick[g]),
      .busy_o       (busy[g])
    );
  end

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Bench for multi_rate_tick_gen: a 4-channel and a 3-channel build against a reference model.
module tb_multi_rate_tick_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] ch_en = '0;
  logic [3:0] restart = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_oneshot = 1'b0;
  logic [3:0] tick, busy;
  logic [2:0] tick3, busy3;

  int n_chk = 0;
  int n_pass = 0;

  // Model state: index 0..3 -> 4-channel build, 4..6 -> 3-channel build.
  // left = enabled edges still to go before the next expiry.
  int m_left[7];
  int m_div[7];
  bit m_one[7];
  bit m_armed[7];
  bit m_tick[7];

  always #5 clk = ~clk;

  multi_rate_tick_gen #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_en(ch_en), .restart(restart),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
    .tick(tick), .busy(busy)
  );

  multi_rate_tick_gen #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .ch_en(ch_en[2:0]), .restart(restart[2:0]),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
    .tick(tick3), .busy(busy3)
  );

  task automatic model_edge();
    for (int i = 0; i < 7; i++) begin
      int c;
      bit hit, run;
      c   = (i < 4) ? i : i - 4;
      hit = cfg_we && (int'(cfg_ch) == c);
      if (reset) begin
        m_div[i] = 4; m_left[i] = 5; m_one[i] = 0; m_armed[i] = 1; m_tick[i] = 0;
      end else begin
        run = enable && ch_en[c] && m_armed[i];
        m_tick[i] = 0;
        if (restart[c]) begin
          m_left[i]  = (hit ? int'(cfg_div) : m_div[i]) + 1;
          m_armed[i] = 1;
        end else if (run) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_tick[i] = 1;
            m_left[i] = m_div[i] + 1;
            if (m_one[i]) m_armed[i] = 0;
          end
        end
        if (hit) begin
          m_div[i] = int'(cfg_div);
          m_one[i] = cfg_oneshot;
        end
      end
    end
  endtask

  function automatic logic [13:0] exp_all();
    logic [3:0] ta, ba;
    logic [2:0] tb, bb;
    for (int i = 0; i < 4; i++) begin
      ta[i] = m_tick[i];
      ba[i] = m_armed[i] & ch_en[i];
    end
    for (int i = 0; i < 3; i++) begin
      tb[i] = m_tick[4 + i];
      bb[i] = m_armed[4 + i] & ch_en[i];
    end
    return {bb, tb, ba, ta};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1'b1; ch_en = 4'hF; restart = '0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;
  endtask

  task automatic test_reset();
    int first;
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_chk++;
    if ({tick, busy} !== 8'h0F) $display("FAIL reset_state: got %b want %b", {tick, busy}, 8'h0F);
    else n_pass++;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_chk++;
      if ({busy3, tick3, busy, tick} !== exp_all())
        $display("FAIL reset_run: got %b want %b", {busy3, tick3, busy, tick}, exp_all());
      else n_pass++;
      if (tick[0] && first == 0) first = k;
    end
    n_chk++;
    if (first !== 5) $display("FAIL first_tick: got %0d want 5", first);
    else n_pass++;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_chk++;
    if (tick !== 4'h0) $display("FAIL midreset_tick: got %b want 0000", tick);
    else n_pass++;
    first = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (tick[0] && first == 0) first = k;
    end
    n_chk++;
    if (first !== 5) $display("FAIL midreset_first: got %0d want 5", first);
    else n_pass++;
  endtask

  task automatic test_cfg_period();
    int pos[$];
    idle_inputs();
    step();
    step();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2;
    step();
    cfg_we = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_chk++;
      if ({busy3, tick3, busy, tick} !== exp_all())
        $display("FAIL cfg_period: got %b want %b", {busy3, tick3, busy, tick}, exp_all());
      else n_pass++;
      if (tick[1]) pos.push_back(k);
    end
    n_chk++;
    if (pos.size() < 3 || pos[1] - pos[0] != 3 || pos[2] - pos[1] != 3)
      $display("FAIL cfg_new_period: got %0d ticks want period 3", pos.size());
    else n_pass++;
  endtask

  task automatic test_oneshot();
    int first, cnt;
    idle_inputs();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd1; cfg_oneshot = 1'b1; restart = 4'b0100;
    step();
    idle_inputs();
    for (int r = 0; r < 2; r++) begin
      first = 0; cnt = 0;
      for (int k = 1; k <= 6; k++) begin
        step();
        n_chk++;
        if ({busy3, tick3, busy, tick} !== exp_all())
          $display("FAIL oneshot_run: got %b want %b", {busy3, tick3, busy, tick}, exp_all());
        else n_pass++;
        if (tick[2]) begin
          cnt++;
          if (first == 0) first = k;
        end
      end
      n_chk++;
      if (first !== 2 || cnt !== 1 || busy[2] !== 1'b0)
        $display("FAIL oneshot: got first=%0d n=%0d busy=%b want 2 1 0", first, cnt, busy[2]);
      else n_pass++;
      restart = 4'b0100;
      step();
      restart = '0;
    end
  endtask

  task automatic test_pause();
    int first, t3;
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (tick !== 4'h0) $display("FAIL pause_tick: got %b want 0000", tick);
      else n_pass++;
    end
    enable = 1'b1;
    first = 0;
    for (int k = 6; k <= 10; k++) begin
      step();
      if (tick[0] && first == 0) first = k;
    end
    n_chk++;
    if (first !== 8) $display("FAIL pause_delay: got edge %0d want 8", first);
    else n_pass++;
    ch_en = 4'b0111;
    t3 = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      n_chk++;
      if ({busy3, tick3, busy, tick} !== exp_all())
        $display("FAIL chen_run: got %b want %b", {busy3, tick3, busy, tick}, exp_all());
      else n_pass++;
      if (tick[3] || busy[3]) t3++;
    end
    n_chk++;
    if (t3 !== 0) $display("FAIL ch3_frozen: got %0d active cycles want 0", t3);
    else n_pass++;
  endtask

  task automatic test_div0();
    idle_inputs();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0; restart = 4'b0001;
    step();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      step();
      n_chk++;
      if (tick[0] !== 1'b1) $display("FAIL div0_tick: got %b want 1", tick[0]);
      else n_pass++;
    end
    restart = 4'b0001;
    step();
    restart = '0;
    n_chk++;
    if (tick[0] !== 1'b0) $display("FAIL div0_restart: got %b want 0", tick[0]);
    else n_pass++;
    step();
    n_chk++;
    if (tick[0] !== 1'b1) $display("FAIL div0_after: got %b want 1", tick[0]);
    else n_pass++;
  endtask

  task automatic test_bad_ch();
    int n[3];
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7; cfg_oneshot = 1'b1;
    n = '{0, 0, 0};
    for (int k = 1; k <= 15; k++) begin
      step();
      cfg_we = 1'b0;
      n_chk++;
      if ({busy3, tick3, busy, tick} !== exp_all())
        $display("FAIL bad_ch_run: got %b want %b", {busy3, tick3, busy, tick}, exp_all());
      else n_pass++;
      for (int i = 0; i < 3; i++) if (tick3[i]) n[i]++;
    end
    n_chk++;
    if (n[0] != 3 || n[1] != 3 || n[2] != 3)
      $display("FAIL bad_ch_ticks: got %0d %0d %0d want 3 3 3", n[0], n[1], n[2]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset       = ($urandom_range(99) == 0);
      enable      = ($urandom_range(7) != 0);
      for (int i = 0; i < 4; i++) begin
        ch_en[i]   = ($urandom_range(7) != 0);
        restart[i] = ($urandom_range(15) == 0);
      end
      cfg_we      = ($urandom_range(7) == 0);
      cfg_ch      = 2'($urandom_range(3));
      cfg_div     = 8'($urandom_range(9));
      cfg_oneshot = ($urandom_range(3) == 0);
      step();
      n_chk++;
      if ({busy3, tick3, busy, tick} !== exp_all())
        $display("FAIL random: cycle %0d got %b want %b", k, {busy3, tick3, busy, tick},
                 exp_all());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_cfg_period();
    test_oneshot();
    test_pause();
    test_div0();
    test_bad_ch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
